mfp_ahb_intc: RTL and testbench
===============================

MFP_AHB_INTC -- requirements
Module: mfp_ahb_intc

Interface
REQ-001 Parameter N_IRQ, default 8, number of interrupt input channels; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth on each IRQ input; legal range 2..3.
REQ-003 HCLK  input  1  single clock for all logic; one clock, no other clock domains inside the block.
REQ-004 HRESETn  input  1  reset, synchronous, active-low, sampled on rising HCLK.
REQ-005 HSEL  input  1  AHB-Lite slave select.
REQ-006 HADDR  input  32  AHB address; only HADDR[4:2] decoded.
REQ-007 HTRANS  input  2  AHB transfer type; NONSEQ/SEQ = active, IDLE/BUSY = no access.
REQ-008 HWRITE  input  1  1 = write.
REQ-009 HSIZE  input  3  transfer size; only 3'b010 (word) writes take effect.
REQ-010 HWDATA  input  32  write data, data phase.
REQ-011 HRDATA  output  32  read data, data phase.
REQ-012 HREADY  output  1  constant 1 (zero wait states).
REQ-013 HRESP  output  1  constant 0 (OKAY).
REQ-014 IRQ_IN  input  N_IRQ  asynchronous interrupt sources.
REQ-015 SI_Int  output  8  legacy core interrupt pins.
REQ-016 SI_EICPresent  output  1  EIC mode indicator to core.
REQ-017 SI_EICVector  output  6  EIC vector number, 0 = none.

Function
REQ-018 Register map (word offset): 0x00 RAW RO; 0x04 ENABLE RW; 0x08 MODE RW (1 = edge, 0 = level); 0x0C POLARITY RW (1 = active-low); 0x10 PENDING R/W1C; 0x14 CTRL RW (bit0 GIE, bit1 EIC); 0x18 VECTOR RO; 0x1C SWTRIG WO (reads 0).
REQ-019 Address phase is captured when HSEL & HTRANS[1] & HREADY. The write takes effect at the end of the following (data) cycle using HWDATA.
REQ-020 Read data is driven in the data phase directly after the captured address phase. It reflects register state at the start of that data cycle.
REQ-021 Register bits at index >= N_IRQ read 0 and ignore writes. CTRL bits [31:2] and VECTOR bits [30:5] read 0.
REQ-022 Each IRQ_IN bit passes through a SYNC_STAGES-flop synchroniser. It is then XORed with POLARITY to form RAW (active = 1).
REQ-023 Edge channel: an active rising edge is RAW=1 with prev=0, where prev is a per-channel flop of RAW. It sets the PENDING flop.
REQ-024 Level channel: the PENDING bit reads as the RAW bit. The internal edge-pending flop is held at 0 while MODE=0.
REQ-025 Writing 1 to PENDING clears the edge-pending flop. If a set from an edge or SWTRIG occurs in the same cycle, the set wins. W1C on level channels is ignored.
REQ-026 Writing 1 to SWTRIG sets pending on edge channels only.
REQ-027 A write to POLARITY also loads prev with the new polarity-corrected sync value, so a polarity change never creates an edge.
REQ-028 ACTIVE = PENDING & ENABLE, gated by CTRL.GIE.
REQ-029 VECTOR: bit31 = |ACTIVE; [4:0] = lowest index set in ACTIVE (lowest index is highest priority), 0 when none.
REQ-030 Legacy mode (CTRL.EIC=0): SI_Int[k] = OR of ACTIVE[i] over all i with i mod 6 == k, for k = 0..5. SI_Int[7:6] = 0. SI_EICPresent = 0. SI_EICVector = 0.
REQ-031 EIC mode (CTRL.EIC=1): SI_Int = 0 and SI_EICPresent = 1. SI_EICVector = VECTOR[4:0]+1 when VECTOR valid, otherwise 0.
REQ-032 SI_Int, SI_EICPresent and SI_EICVector are registered, one HCLK after ACTIVE.
REQ-033 Latency from an IRQ_IN edge to the PENDING readback is SYNC_STAGES+1 cycles. Latency from the IRQ_IN edge to the core pins is SYNC_STAGES+2 cycles.
REQ-034 Switching MODE from edge to level discards the edge-pending state of that channel.

Reset
REQ-035 While HRESETn=0 at a rising HCLK, the following clear to 0: all registers, synchronisers, prev flops and pending flops, plus SI_Int, SI_EICPresent, SI_EICVector and HRDATA.
REQ-036 A reset asserted mid-transfer abandons any pending data-phase write.
REQ-037 The first access is accepted in the first cycle after HRESETn returns to 1.

Verification
REQ-038 Setup: N_IRQ=8, SYNC_STAGES=2, ENABLE=0xFF, MODE=0xFF, GIE=1. Pulse IRQ_IN[3] high for 1 cycle. Required: PENDING=0x08 and SI_Int[3]=1 after 4 cycles, and both stay set. W1C 0x08 -> SI_Int=0.
REQ-039 Setup: level mode, POLARITY=0x01, IRQ_IN[0]=0. Required: RAW[0]=1, PENDING[0]=1, SI_Int[0]=1. Drive IRQ_IN[0]=1 -> all three clear within 4 cycles. A write of POLARITY alone causes no latched edge.
REQ-040 Setup: EIC=1, IRQ 5 and IRQ 2 pending and enabled. Required: VECTOR=0x80000002, SI_EICVector=3, SI_EICPresent=1, SI_Int=0. Clear IRQ 2 -> SI_EICVector=6.
REQ-041 Same-cycle case: a W1C of bit 1 coincides with a new edge on IRQ 1. Required: PENDING[1] remains 1.
REQ-042 Setup: N_IRQ=12, IRQ 7 and IRQ 1 both active in legacy mode. Required: SI_Int=0x02, since IRQ 7 folds onto line 1. A write of 0xFFFFFFFF to ENABLE reads back 0x00000FFF.
REQ-043 Scenario: assert HRESETn=0 in the data phase of an ENABLE write. Required: ENABLE=0, all outputs 0 one cycle later, and the write does not take effect.

Source files
------------

// File: rtl/mfp_ahb_intc.sv
// AHB-Lite interrupt controller: sync'd IRQ inputs, edge/level pending, legacy SI_Int or EIC vector output.
// Zero-wait-state slave; IRQ edge -> PENDING in SYNC_STAGES+1 cycles, -> core pins in SYNC_STAGES+2.
module mfp_ahb_intc #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADY,
  output logic             HRESP,
  input  logic [N_IRQ-1:0] IRQ_IN,
  output logic [7:0]       SI_Int,
  output logic             SI_EICPresent,
  output logic [5:0]       SI_EICVector
);

  localparam logic [2:0] A_RAW  = 3'd0;
  localparam logic [2:0] A_EN   = 3'd1;
  localparam logic [2:0] A_MODE = 3'd2;
  localparam logic [2:0] A_POL  = 3'd3;
  localparam logic [2:0] A_PEND = 3'd4;
  localparam logic [2:0] A_CTRL = 3'd5;
  localparam logic [2:0] A_VEC  = 3'd6;
  localparam logic [2:0] A_SW   = 3'd7;

  logic                                rd_q, wr_q, word_q;
  logic [2:0]                          addr_q;
  logic [N_IRQ-1:0]                    enable_q, mode_q, pol_q, prev_q, epend_q;
  logic [1:0]                          ctrl_q;
  logic [SYNC_STAGES-1:0][N_IRQ-1:0]   sync_q;

  logic [N_IRQ-1:0] sync_out, raw, pending, active, wdat, mode_nxt;
  logic [N_IRQ-1:0] edge_set, sw_set, w1c;
  logic             wr_en, any_act;
  logic [4:0]       vec_idx;
  logic [31:0]      vector;
  logic [7:0]       si_int_nxt;
  logic [5:0]       eic_vec_nxt;
  logic             unused;

  function automatic logic [31:0] ext(input logic [N_IRQ-1:0] v);
    ext = '0;
    ext[N_IRQ-1:0] = v;
  endfunction

  assign HREADY   = 1'b1;
  assign HRESP    = 1'b0;
  assign unused   = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  assign wr_en    = wr_q & word_q;
  assign wdat     = HWDATA[N_IRQ-1:0];
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign raw      = sync_out ^ pol_q;
  // Level channels read straight through; edge channels read the latched flop.
  assign pending  = (epend_q & mode_q) | (raw & ~mode_q);
  assign active   = pending & enable_q & {N_IRQ{ctrl_q[0]}};
  assign mode_nxt = (wr_en && addr_q == A_MODE) ? wdat : mode_q;
  assign edge_set = raw & ~prev_q & mode_q;
  assign sw_set   = (wr_en && addr_q == A_SW) ? (wdat & mode_q) : '0;
  assign w1c      = (wr_en && addr_q == A_PEND) ? wdat : '0;

  always_comb begin
    any_act     = |active;
    vec_idx     = '0;
    si_int_nxt  = '0;
    eic_vec_nxt = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (active[i]) vec_idx = 5'(i);
    for (int i = 0; i < N_IRQ; i++)
      si_int_nxt[i % 6] = si_int_nxt[i % 6] | active[i];
    if (ctrl_q[1]) begin
      si_int_nxt  = '0;
      eic_vec_nxt = any_act ? 6'(vec_idx) + 6'd1 : 6'd0;
    end
    vector = {any_act, 26'd0, vec_idx};
  end

  always_comb begin
    HRDATA = '0;
    if (rd_q) begin
      case (addr_q)
        A_RAW:   HRDATA = ext(raw);
        A_EN:    HRDATA = ext(enable_q);
        A_MODE:  HRDATA = ext(mode_q);
        A_POL:   HRDATA = ext(pol_q);
        A_PEND:  HRDATA = ext(pending);
        A_CTRL:  HRDATA = {30'd0, ctrl_q};
        A_VEC:   HRDATA = vector;
        default: HRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      word_q        <= 1'b0;
      addr_q        <= '0;
      enable_q      <= '0;
      mode_q        <= '0;
      pol_q         <= '0;
      ctrl_q        <= '0;
      sync_q        <= '0;
      prev_q        <= '0;
      epend_q       <= '0;
      SI_Int        <= '0;
      SI_EICPresent <= 1'b0;
      SI_EICVector  <= '0;
    end else begin
      rd_q   <= HSEL & HTRANS[1] & HREADY & ~HWRITE;
      wr_q   <= HSEL & HTRANS[1] & HREADY & HWRITE;
      word_q <= (HSIZE == 3'b010);
      addr_q <= HADDR[4:2];
      sync_q <= {sync_q[SYNC_STAGES-2:0], IRQ_IN};
      if (wr_en) begin
        case (addr_q)
          A_EN:    enable_q <= wdat;
          A_MODE:  mode_q   <= wdat;
          A_POL:   pol_q    <= wdat;
          A_CTRL:  ctrl_q   <= HWDATA[1:0];
          default: ;
        endcase
      end
      // Reload prev under the new polarity so a polarity flip is never seen as an edge.
      prev_q  <= (wr_en && addr_q == A_POL) ? (sync_out ^ wdat) : raw;
      epend_q <= ((epend_q & ~w1c) | edge_set | sw_set) & mode_nxt;
      SI_Int        <= si_int_nxt;
      SI_EICPresent <= ctrl_q[1];
      SI_EICVector  <= eic_vec_nxt;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_intc.sv
// Bench for mfp_ahb_intc: an 8-channel and a 12-channel instance share one AHB bus.
module tb_mfp_ahb_intc;

  localparam logic [4:0] R_RAW = 5'h00, R_EN = 5'h04, R_MODE = 5'h08, R_POL = 5'h0C;
  localparam logic [4:0] R_PEND = 5'h10, R_CTRL = 5'h14, R_VEC = 5'h18, R_SW = 5'h1C;

  logic        HCLK = 1'b0;
  logic        HRESETn, HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [7:0]  irq8;
  logic [11:0] irq12;
  logic [31:0] rd8, rd12;
  logic        rdy8, rdy12, resp8, resp12, p8, p12;
  logic [7:0]  si8, si12;
  logic [5:0]  v8, v12;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] r8, r12, e;

  always #5 HCLK = ~HCLK;

  mfp_ahb_intc #(.N_IRQ(8), .SYNC_STAGES(2)) dut8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(rd8), .HREADY(rdy8),
    .HRESP(resp8), .IRQ_IN(irq8), .SI_Int(si8), .SI_EICPresent(p8), .SI_EICVector(v8));

  mfp_ahb_intc #(.N_IRQ(12), .SYNC_STAGES(2)) dut12 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(rd12), .HREADY(rdy12),
    .HRESP(resp12), .IRQ_IN(irq12), .SI_Int(si12), .SI_EICPresent(p12), .SI_EICVector(v12));

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [2:0] sz = 3'b010);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {27'd0, a}; HSIZE = sz;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] o8, output logic [31:0] o12);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {27'd0, a}; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    o8 = rd8; o12 = rd12;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
    HSIZE = 3'b010; HWDATA = '0; irq8 = '0; irq12 = '0;
    idle(3);
    HRESETn = 1'b1;
    n_chk++; if ({si8, p8, v8} !== 15'd0) begin n_fail++; $display("FAIL reset_pins got %h want 0", {si8, p8, v8}); end
    n_chk++; if ({rdy8, resp8, rdy12, resp12} !== 4'b1010) begin n_fail++; $display("FAIL ready_resp got %b want 1010", {rdy8, resp8, rdy12, resp12}); end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h0);
      bus_read(5'(i * 4), r8, r12);
      e = exp_q.pop_front();
      n_chk++; if (r8 !== e || r12 !== e) begin n_fail++; $display("FAIL reset_reg%0d got %h/%h want %h", i, r8, r12, e); end
    end
  endtask

  task automatic test_edge;
    bus_write(R_EN, 32'hFF); bus_write(R_MODE, 32'hFF); bus_write(R_CTRL, 32'h1);
    irq8[3] = 1'b1; idle(1); irq8[3] = 1'b0;
    idle(2);
    n_chk++; if (si8 !== 8'h00) begin n_fail++; $display("FAIL edge_early got %h want 00", si8); end
    idle(1);
    n_chk++; if (si8 !== 8'h08) begin n_fail++; $display("FAIL edge_si got %h want 08", si8); end
    exp_q.push_back(32'h08);
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL edge_pend got %h want %h", r8, e); end
    idle(5);
    n_chk++; if (si8 !== 8'h08) begin n_fail++; $display("FAIL edge_hold got %h want 08", si8); end
    bus_write(R_PEND, 32'h08); idle(1);
    n_chk++; if (si8 !== 8'h00) begin n_fail++; $display("FAIL edge_w1c_si got %h want 00", si8); end
    exp_q.push_back(32'h0);
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL edge_w1c_pend got %h want %h", r8, e); end
  endtask

  task automatic test_level_polarity;
    bus_write(R_POL, 32'h01); idle(1);
    exp_q.push_back(32'h00); exp_q.push_back(32'h01);
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL pol_no_edge got %h want %h", r8, e); end
    bus_read(R_RAW, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL pol_raw got %h want %h", r8, e); end
    bus_write(R_MODE, 32'hFE); idle(1);
    n_chk++; if (si8 !== 8'h01) begin n_fail++; $display("FAIL level_si got %h want 01", si8); end
    exp_q.push_back(32'h01);
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL level_pend got %h want %h", r8, e); end
    irq8[0] = 1'b1; idle(4);
    n_chk++; if (si8 !== 8'h00) begin n_fail++; $display("FAIL level_off_si got %h want 00", si8); end
    exp_q.push_back(32'h00); exp_q.push_back(32'h00);
    bus_read(R_RAW, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL level_off_raw got %h want %h", r8, e); end
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL level_off_pend got %h want %h", r8, e); end
    irq8[0] = 1'b0; idle(3);
    bus_write(R_POL, 32'h0); bus_write(R_MODE, 32'hFF); idle(2);
  endtask

  task automatic test_eic;
    bus_write(R_CTRL, 32'h3);
    irq8[5] = 1'b1; irq8[2] = 1'b1; idle(1); irq8[5] = 1'b0; irq8[2] = 1'b0;
    idle(3);
    n_chk++; if ({p8, v8, si8} !== {1'b1, 6'd3, 8'h00}) begin n_fail++; $display("FAIL eic_pins got p=%b v=%0d si=%h want p=1 v=3 si=00", p8, v8, si8); end
    exp_q.push_back(32'h8000_0002);
    bus_read(R_VEC, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL eic_vector got %h want %h", r8, e); end
    bus_write(R_PEND, 32'h04); idle(1);
    n_chk++; if (v8 !== 6'd6) begin n_fail++; $display("FAIL eic_next got %0d want 6", v8); end
    exp_q.push_back(32'h8000_0005);
    bus_read(R_VEC, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL eic_vector2 got %h want %h", r8, e); end
    bus_write(R_PEND, 32'h20); bus_write(R_CTRL, 32'h1); idle(1);
    n_chk++; if ({p8, v8} !== 7'd0) begin n_fail++; $display("FAIL eic_off got p=%b v=%0d want 0 0", p8, v8); end
  endtask

  task automatic test_same_cycle;
    irq8[1] = 1'b1; idle(1); irq8[1] = 1'b0; idle(4);
    irq8[1] = 1'b1; idle(1);
    bus_write(R_PEND, 32'h02);
    exp_q.push_back(32'h02);
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL set_wins got %h want %h", r8, e); end
    irq8[1] = 1'b0; idle(3);
    bus_write(R_PEND, 32'h02);
    exp_q.push_back(32'h00);
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL w1c_alone got %h want %h", r8, e); end
  endtask

  task automatic test_swtrig_mode;
    bus_write(R_MODE, 32'h0F); bus_write(R_SW, 32'hFF);
    exp_q.push_back(32'h0F); exp_q.push_back(32'h00);
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL swtrig_edge_only got %h want %h", r8, e); end
    bus_read(R_SW, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL swtrig_read got %h want %h", r8, e); end
    bus_write(R_MODE, 32'h00); bus_write(R_MODE, 32'h0F);
    exp_q.push_back(32'h00);
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL mode_discard got %h want %h", r8, e); end
    bus_write(R_MODE, 32'hFF);
    bus_write(R_EN, 32'h00, 3'b000);
    exp_q.push_back(32'hFF);
    bus_read(R_EN, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL byte_write_ignored got %h want %h", r8, e); end
  endtask

  task automatic test_fold12;
    bus_write(R_EN, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF); exp_q.push_back(32'h0000_0FFF);
    bus_read(R_EN, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL en_mask8 got %h want %h", r8, e); end
    e = exp_q.pop_front();
    n_chk++; if (r12 !== e) begin n_fail++; $display("FAIL en_mask12 got %h want %h", r12, e); end
    irq12[7] = 1'b1; irq12[1] = 1'b1; idle(1); irq12 = '0;
    idle(3);
    n_chk++; if (si12 !== 8'h02) begin n_fail++; $display("FAIL fold_si got %h want 02", si12); end
    n_chk++; if (si8 !== 8'h00) begin n_fail++; $display("FAIL fold_other got %h want 00", si8); end
    exp_q.push_back(32'h0000_0082);
    bus_read(R_PEND, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r12 !== e) begin n_fail++; $display("FAIL fold_pend got %h want %h", r12, e); end
    bus_write(R_CTRL, 32'h0); idle(1);
    n_chk++; if (si12 !== 8'h00) begin n_fail++; $display("FAIL gie_off got %h want 00", si12); end
    bus_write(R_CTRL, 32'h1); bus_write(R_PEND, 32'hFFFF_FFFF); bus_write(R_EN, 32'hFF);
  endtask

  task automatic test_reset_mid;
    bus_write(R_SW, 32'h01); idle(1);
    n_chk++; if (si8 !== 8'h01) begin n_fail++; $display("FAIL premid_si got %h want 01", si8); end
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {27'd0, R_EN}; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h55; HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    n_chk++; if ({si8, p8, v8, rd8} !== 47'd0) begin n_fail++; $display("FAIL midrst_pins got %h want 0", {si8, p8, v8, rd8}); end
    exp_q.push_back(32'h00);
    bus_read(R_EN, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL midrst_enable got %h want %h", r8, e); end
    bus_write(R_EN, 32'h3C);
    exp_q.push_back(32'h3C);
    bus_read(R_EN, r8, r12);
    e = exp_q.pop_front();
    n_chk++; if (r8 !== e) begin n_fail++; $display("FAIL post_rst_access got %h want %h", r8, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_edge;
    test_level_polarity;
    test_eic;
    test_same_cycle;
    test_swtrig_mode;
    test_fold12;
    test_reset_mid;
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
